// File: rtl/note_freq_if.sv
// Tone input and decoded-note outputs of the note frequency detector.
// The slave side is the detector; the master side drives the tone and observes the result.
interface note_freq_if #(
    parameter int CNT_W = 20
);
    logic             tone_in;
    logic [3:0]       note_out;
    logic             note_valid;
    logic             new_note;
    logic [CNT_W-1:0] period_out;

    modport slave (
        input  tone_in,
        output note_out, note_valid, new_note, period_out
    );

    modport master (
        output tone_in,
        input  note_out, note_valid, new_note, period_out
    );
endinterface

// File: rtl/note_freq_detector.sv
// Measures the rise-to-rise period of a square-wave tone and decodes it to a one-hot note.
// Outputs update 3 clk edges after a tone rising edge; no backpressure (free-running observer).
module note_freq_detector #(
    parameter int CNT_W        = 20,
    parameter int NOTE0_PERIOD = 191110,
    parameter int NOTE1_PERIOD = 151685,
    parameter int NOTE2_PERIOD = 127551,
    parameter int NOTE3_PERIOD = 95557,
    parameter int TOL          = 2000,
    parameter int CONFIRM      = 3,
    parameter int TIMEOUT      = 400000
) (
    input  logic        clk,
    input  logic        reset,
    note_freq_if.slave  io
);
    localparam int MC_W = $clog2(CONFIRM + 1);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

    state_t           state_q;
    logic             s1_q, s2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   period_d;
    logic [CNT_W-1:0] period_sat;
    logic [31:0]      p32;
    logic [3:0]       class_d;
    logic [3:0]       cand_q;
    logic [MC_W-1:0]  match_q, match_d;
    logic             lock_d;
    logic             rise, timeout;
    logic [3:0]       note_q;
    logic             valid_q, new_q;
    logic [CNT_W-1:0] period_q;

    function automatic logic near(input logic [31:0] p, input logic [31:0] tgt);
        near = ((p >= tgt) ? (p - tgt) : (tgt - p)) <= 32'(TOL);
    endfunction

    assign rise    = s2_q & ~prev_q;
    assign timeout = (state_q != S_IDLE) && !rise && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        period_d   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        period_sat = period_d[CNT_W] ? '1 : period_d[CNT_W-1:0];
        p32        = 32'(period_d);
        // Lowest index wins when windows overlap.
        class_d = 4'b0000;
        if (near(p32, 32'(NOTE0_PERIOD)))      class_d = 4'b0001;
        else if (near(p32, 32'(NOTE1_PERIOD))) class_d = 4'b0010;
        else if (near(p32, 32'(NOTE2_PERIOD))) class_d = 4'b0100;
        else if (near(p32, 32'(NOTE3_PERIOD))) class_d = 4'b1000;
        if (class_d != 4'b0000 && class_d == cand_q)
            match_d = match_q + MC_W'(1);
        else
            match_d = MC_W'(class_d != 4'b0000);
        lock_d = (class_d != 4'b0000) && (int'(match_d) >= CONFIRM);
        cnt_d  = rise ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            cand_q   <= '0;
            match_q  <= '0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            new_q    <= 1'b0;
            period_q <= '0;
        end else begin
            s1_q   <= io.tone_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            cnt_q  <= cnt_d;
            new_q  <= 1'b0;
            if (timeout) begin
                state_q  <= S_IDLE;
                note_q   <= '0;
                valid_q  <= 1'b0;
                period_q <= '0;
                match_q  <= '0;
                cand_q   <= '0;
            end else if (rise) begin
                case (state_q)
                    // First edge only arms the counter; no period exists yet.
                    S_IDLE: begin
                        state_q <= S_MEASURE;
                        match_q <= '0;
                    end
                    S_MEASURE: begin
                        period_q <= period_sat;
                        cand_q   <= class_d;
                        match_q  <= match_d;
                        if (lock_d) begin
                            state_q <= S_LOCKED;
                            note_q  <= class_d;
                            valid_q <= 1'b1;
                            new_q   <= 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        period_q <= period_sat;
                        if (class_d != cand_q) begin
                            state_q <= S_MEASURE;
                            note_q  <= '0;
                            valid_q <= 1'b0;
                            cand_q  <= class_d;
                            match_q <= match_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign io.note_out   = note_q;
    assign io.note_valid = valid_q;
    assign io.new_note   = new_q;
    assign io.period_out = period_q;
endmodule

// File: tb/tb_note_freq_detector.sv
// Directed stimulus with a queued scoreboard; the monitor checks every output change and its cycle.
// Note periods are scaled down (about 1/200) to keep the run short.
module tb_note_freq_detector;
    localparam int CNT_W   = 12;
    localparam int N0      = 956;
    localparam int N1      = 758;
    localparam int N2      = 638;
    localparam int N3      = 478;
    localparam int TOL     = 10;
    localparam int CONFIRM = 3;
    localparam int TIMEOUT = 2000;

    typedef struct {
        string            name;
        int               cyc;
        logic [3:0]       note;
        logic             vld;
        logic             nn;
        logic [CNT_W-1:0] per;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    exp_t mon_e;
    logic [3:0]       pn;
    logic             pv, pnn;
    logic [CNT_W-1:0] pp;

    note_freq_if #(.CNT_W(CNT_W)) bus();

    note_freq_detector #(
        .CNT_W(CNT_W), .NOTE0_PERIOD(N0), .NOTE1_PERIOD(N1), .NOTE2_PERIOD(N2),
        .NOTE3_PERIOD(N3), .TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input string name, input int dly, input logic [3:0] n,
                             input logic v, input logic nn, input int per);
        exp_t e;
        e.name = name;
        e.cyc  = cyc + dly;
        e.note = n;
        e.vld  = v;
        e.nn   = nn;
        e.per  = CNT_W'(per);
        q.push_back(e);
    endtask

    // One rising edge now, next rising edge exactly p cycles later.
    task automatic pulse(input int p);
        bus.tone_in = 1'b1;
        repeat (p / 2) @(negedge clk);
        bus.tone_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        expect_at(name, 1, 4'b0000, 1'b0, 1'b0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Edge 1 arms, edge 2 records the period, edge 4 locks (third matching period).
    task automatic run_same(input string name, input int p, input logic [3:0] note, input int n);
        for (int i = 1; i <= n; i++) begin
            if (i == 2) expect_at({name, "_period"}, 3, 4'b0000, 1'b0, 1'b0, p);
            if (i == 4 && note != 4'b0000) begin
                expect_at({name, "_lock"}, 3, note, 1'b1, 1'b1, p);
                expect_at({name, "_pulse_end"}, 4, note, 1'b1, 1'b0, p);
            end
            pulse(p);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (bus.note_out !== pn || bus.note_valid !== pv ||
                       bus.new_note !== pnn || bus.period_out !== pp)) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change cyc=%0d: got note=%b vld=%b nn=%b per=%0d, required no change",
                         cyc, bus.note_out, bus.note_valid, bus.new_note, bus.period_out);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.cyc != cyc || bus.note_out !== mon_e.note || bus.note_valid !== mon_e.vld ||
                    bus.new_note !== mon_e.nn || bus.period_out !== mon_e.per) begin
                    fails++;
                    $display("FAIL %s: got cyc=%0d note=%b vld=%b nn=%b per=%0d, required cyc=%0d note=%b vld=%b nn=%b per=%0d",
                             mon_e.name, cyc, bus.note_out, bus.note_valid, bus.new_note, bus.period_out,
                             mon_e.cyc, mon_e.note, mon_e.vld, mon_e.nn, mon_e.per);
                end
            end
            pn  = bus.note_out;
            pv  = bus.note_valid;
            pnn = bus.new_note;
            pp  = bus.period_out;
        end
    end

    initial begin
        bus.tone_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.note_out !== 4'b0000 || bus.note_valid !== 1'b0 ||
            bus.new_note !== 1'b0 || bus.period_out !== '0) begin
            fails++;
            $display("FAIL reset_state: got note=%b vld=%b nn=%b per=%0d, required all zero",
                     bus.note_out, bus.note_valid, bus.new_note, bus.period_out);
        end
        pn = 4'b0000; pv = 1'b0; pnn = 1'b0; pp = '0;
        mon_en = 1'b1;

        // Lock on E4, then reset mid-lock and relock.
        run_same("e4", N1, 4'b0010, 5);
        do_reset("reset_midlock");
        run_same("e4_relock", N1, 4'b0010, 5);
        do_reset("reset_after_relock");

        // Tolerance boundary: +TOL locks, +TOL+1 never matches.
        run_same("tol_in", N0 + TOL, 4'b0001, 5);
        do_reset("reset_tol_in");
        run_same("tol_out", N0 + TOL + 1, 4'b0000, 5);
        do_reset("reset_tol_out");

        // Note change G4 -> C5: edge 5 still measures G4, edge 6 drops, edge 8 relocks.
        run_same("g4", N2, 4'b0100, 4);
        pulse(N3);
        expect_at("chg_drop", 3, 4'b0000, 1'b0, 1'b0, N3);
        pulse(N3);
        pulse(N3);
        expect_at("chg_lock", 3, 4'b1000, 1'b1, 1'b1, N3);
        expect_at("chg_pulse_end", 4, 4'b1000, 1'b1, 1'b0, N3);
        pulse(N3);
        do_reset("reset_chg");

        // Silence after lock on C4, then one arming edge before a period is recorded.
        run_same("c4", N0, 4'b0001, 3);
        expect_at("c4_lock", 3, 4'b0001, 1'b1, 1'b1, N0);
        expect_at("c4_pulse_end", 4, 4'b0001, 1'b1, 1'b0, N0);
        expect_at("silence_timeout", 4 + TIMEOUT, 4'b0000, 1'b0, 1'b0, 0);
        pulse(N0);
        repeat (TIMEOUT) @(negedge clk);
        pulse(N0);
        expect_at("rearm_period", 3, 4'b0000, 1'b0, 1'b0, N0);
        pulse(N0);
        do_reset("reset_silence");

        // Alternating notes never lock; period_out follows each period.
        for (int i = 1; i <= 10; i++) begin
            if (i >= 2) expect_at("alt_period", 3, 4'b0000, 1'b0, 1'b0, (i % 2 == 0) ? N1 : N2);
            pulse((i % 2 == 1) ? N1 : N2);
        end
        do_reset("reset_alt");

        repeat (10) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: got %0d unseen, required 0 (next %s at cyc %0d)",
                     q.size(), q[0].name, q[0].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/note_freq_detector.md
Name: note_freq_detector

Overview:
- Receive-side counterpart of the keyboard note player: measures the period of an incoming square-wave tone (speaker/GPIO line) and decodes which of four notes is sounding.
- Output uses the same one-hot 4-bit note encoding the player accepts.
- Used for loopback self-test of the player and for capturing tones from an external source.

Parameters:
- CNT_W, 20, width of period counter and period_out
- NOTE0_PERIOD, 191110, clk cycles per period for note bit 0 (C4 at 50 MHz)
- NOTE1_PERIOD, 151685, period for note bit 1 (E4)
- NOTE2_PERIOD, 127551, period for note bit 2 (G4)
- NOTE3_PERIOD, 95557, period for note bit 3 (C5)
- TOL, 2000, max absolute period deviation (cycles) still counted as a match
- CONFIRM, 3, consecutive matching periods required to lock
- TIMEOUT, 400000, cycles with no rising edge before declaring silence (must be < 2^CNT_W and > every NOTEn_PERIOD+TOL)

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- tone_in  in  1  asynchronous square-wave input
- note_out  out  4  one-hot decoded note; 0 when not locked
- note_valid  out  1  high while locked on a note
- new_note  out  1  one-cycle pulse on entry to LOCKED
- period_out  out  CNT_W  last measured period in clk cycles

Behaviour:
- Input conditioning: 2-flop synchronizer (s1, s2) plus prev register, all reset to 0; rise = s2 & ~prev.
- Outputs are registered. Update latency is 3 clk edges after the tone_in rising edge.
- Period counter cnt:
  - Cleared to 0 on a rise cycle; otherwise increments, saturating at 2^CNT_W-1.
  - Measured period P = cnt+1 (sampled before clearing), computed at CNT_W+1 bits so there is no wrap.
- Classification:
  - Match n if |P - NOTEn_PERIOD| <= TOL.
  - If several match, the lowest index wins.
  - Otherwise result is no-match (class 0).
- Reset values: note_out=0, note_valid=0, new_note=0, period_out=0, state=IDLE, cnt=0, candidate=0, match_cnt=0.
- IDLE: on rise -> MEASURE, cnt=0, match_cnt=0. No period is recorded for the first edge.
- MEASURE: on rise:
  - period_out<=P.
  - If class is nonzero and equals candidate: match_cnt++.
  - Else: candidate<=class, match_cnt<=(class!=0).
  - When match_cnt reaches CONFIRM -> LOCKED: note_out<=candidate, note_valid<=1, new_note pulses 1 cycle.
- LOCKED: on rise:
  - period_out<=P.
  - Same class: stay; outputs unchanged, no new_note.
  - Different class or no-match: -> MEASURE; note_valid<=0, note_out<=0, candidate<=class, match_cnt<=(class!=0).
  - A new note therefore needs CONFIRM periods to lock. First differing period drops valid; with CONFIRM=3, the lock comes on the 3rd new period.
- Timeout:
  - Applies in MEASURE or LOCKED when cnt==TIMEOUT and no rise that cycle.
  - Action: -> IDLE; note_out=0, note_valid=0, period_out=0, match_cnt=0, candidate=0.
- Rise and cnt==TIMEOUT in the same cycle: the rise is processed as a measurement; P exceeds all windows, so it is no-match.
- Reset mid-operation: immediate return to reset values on the next clk edge, regardless of state.
  - If tone_in is high at reset release, the synchronizer produces one rise; from IDLE this only arms.
- new_note is never asserted when note_valid=0 after the update.
- Duty cycle is irrelevant; only rising edges are used.

Test Plan:
- Reset: toggle tone_in at period 151685, assert reset 2 cycles mid-lock -> next cycle note_out=0, note_valid=0, period_out=0, new_note=0; relock needs 1 arming edge + 3 periods.
- Lock E4: 5 rising edges at period 151685 -> edges 1-3 no valid; on 4th edge (+3 clk) note_out=4'b0010, note_valid=1, new_note high exactly 1 cycle, period_out=151685; 5th edge keeps lock with no new_note.
- Tolerance edges: periods 193110 (+2000) x4 -> locks note_out=4'b0001; fresh run with 193111 (+2001) x4 -> never valid, period_out=193111.
- Note change: locked on 127551 (4'b0100), switch to 95557 -> 1st new period note_valid=0, note_out=0; 3rd new period note_out=4'b1000, note_valid=1, new_note pulse.
- Silence: locked on C4, hold tone_in low -> 400000 cycles after last rise (+ sync latency) note_valid=0, note_out=0, period_out=0; next rise only arms, with no period recorded.
- Alternating 151685/127551 periods for 10 edges -> note_valid never asserts, period_out tracks each value.
